adder_accum_sched: RTL and testbench

- Multi-operand modular accumulator scheduler for the SHA-256 round datapath.
- Time-multiplexes a single shared 32-bit adder (adder_csla_cla) to sum a run of N operands, one operand per accepted beat. Typical run: T1 = h + Σ1 + Ch + K + W.
- Uses valid/ready handshakes on the command, operand and result interfaces.
- Sits between the round controller and the round register file. Replaces a tree of parallel adders with one adder plus sequencing.

---
 rtl/sha_adder_pkg.sv | 24 ++
 rtl/adder_csla_cla.sv | 57 +++++
 rtl/adder_accum_sched.sv | 108 ++++++++++
 tb/tb_adder_accum_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_adder_pkg.sv
// Shared constants and state type for the SHA-256 multi-operand accumulator.
package sha_adder_pkg;

  localparam int WIDTH   = 32;
  localparam int MAX_OPS = 8;
  localparam int CW      = $clog2(MAX_OPS + 1);
  localparam int KW      = $clog2(MAX_OPS);

  // Scheduler states. IDLE waits for a command, ACCUM folds operands into
  // the accumulator, DONE presents the result until it is consumed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp a requested operand count to the largest run the block supports.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cnt);
    logic [CW-1:0] max_c;
    max_c = CW'(MAX_OPS);
    clamp_count = (cnt > max_c) ? max_c : cnt;
  endfunction

endpackage

// File: rtl/adder_csla_cla.sv
// Shared 32-bit adder: 8-bit generate/propagate blocks combined as a
// carry-select chain. Upper blocks precompute both carry-in cases and the
// real block carry picks one, so the long carry path is just the mux chain.
module adder_csla_cla
  import sha_adder_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int NG = WIDTH / 8;

  // One 8-bit block: generate/propagate terms resolved into per-bit carries.
  // Returns {carry_out, sum[7:0]}.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin);
    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    cla8 = {c[8], p ^ c[7:0]};
  endfunction

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  // Carry-select chain across the 8-bit blocks.
  always_comb begin
    logic       cin;
    logic [8:0] r0;
    logic [8:0] r1;
    sum_d = '0;
    cin   = i_carry;
    r0    = '0;
    r1    = '0;
    for (int g = 0; g < NG; g++) begin
      r0 = cla8(i_a[g*8 +: 8], i_b[g*8 +: 8], 1'b0);
      r1 = cla8(i_a[g*8 +: 8], i_b[g*8 +: 8], 1'b1);
      sum_d[g*8 +: 8] = cin ? r1[7:0] : r0[7:0];
      cin             = cin ? r1[8]   : r0[8];
    end
    carry_d = cin;
  end

  assign o_sum   = sum_d;
  assign o_carry = carry_d;

endmodule

// File: rtl/adder_accum_sched.sv
// Multi-operand modular accumulator for the SHA-256 round datapath.
// One shared adder is time-multiplexed over a run of up to MAX_OPS operands.
//
// Handshakes: every interface (start, op, res) transfers on a cycle where
// its valid and ready are both high at the rising clock edge; valid must not
// depend on ready. start is ready only in IDLE, op only in ACCUM and res is
// valid only in DONE, so the three transfers never overlap.
module adder_accum_sched
  import sha_adder_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [CW-1:0]    i_count,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [WIDTH-1:0] i_op,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic [KW-1:0]    o_carry_cnt,
  output logic             o_busy
);

  localparam logic [KW-1:0] CARRY_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    rem_q;
  logic [KW-1:0]    carry_q;

  logic [WIDTH-1:0] add_sum;
  logic             add_co;
  logic             start_hs;
  logic             op_hs;
  logic             res_hs;
  logic [KW-1:0]    carry_d;

  // The only combinational arithmetic path: acc/i_op through the adder.
  adder_csla_cla u_adder (
    .i_a     (acc_q),
    .i_b     (i_op),
    .i_carry (1'b0),
    .o_sum   (add_sum),
    .o_carry (add_co)
  );

  assign start_hs = i_start_valid && (state_q == ST_IDLE);
  assign op_hs    = i_op_valid    && (state_q == ST_ACCUM);
  assign res_hs   = i_res_ready   && (state_q == ST_DONE);

  // Carry counter next value, saturating so a long run never wraps it.
  always_comb begin
    carry_d = carry_q;
    if (add_co && (carry_q != CARRY_MAX)) begin
      carry_d = carry_q + KW'(1);
    end
  end

  // Scheduler FSM with accumulator, remaining-operand and carry registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_hs) begin
            acc_q   <= '0;
            carry_q <= '0;
            rem_q   <= clamp_count(i_count);
            state_q <= (i_count == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (op_hs) begin
            acc_q   <= add_sum;
            carry_q <= carry_d;
            rem_q   <= rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_hs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Interface controls decode straight from the state register.
  assign o_start_ready = (state_q == ST_IDLE);
  assign o_op_ready    = (state_q == ST_ACCUM);
  assign o_res_valid   = (state_q == ST_DONE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_sum         = acc_q;
  assign o_carry_cnt   = carry_q;

endmodule

// File: tb/tb_adder_accum_sched.sv
// Bench for adder_accum_sched: table of runs plus hand-written corner cases,
// expected results queued on stimulus and checked when the result appears.
module tb_adder_accum_sched;
  import sha_adder_pkg::*;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start_valid;
  logic             o_start_ready;
  logic [CW-1:0]    i_count;
  logic             i_op_valid;
  logic             o_op_ready;
  logic [WIDTH-1:0] i_op;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_sum;
  logic [KW-1:0]    o_carry_cnt;
  logic             o_busy;

  adder_accum_sched dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start_valid (i_start_valid),
    .o_start_ready (o_start_ready),
    .i_count       (i_count),
    .i_op_valid    (i_op_valid),
    .o_op_ready    (o_op_ready),
    .i_op          (i_op),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready),
    .o_sum         (o_sum),
    .o_carry_cnt   (o_carry_cnt),
    .o_busy        (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [KW-1:0]    exp_c_q[$];

  typedef struct packed {
    logic [CW-1:0]         count;
    logic [3:0]            n_send;
    logic [7:0][WIDTH-1:0] ops;
    logic [WIDTH-1:0]      exp_sum;
    logic [KW-1:0]         exp_carry;
    logic [3:0]            gap_at;   // 15 = no gap
    logic [3:0]            gap_len;
    logic [3:0]            hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 33-bit addition, carry count saturating at 7.
  task automatic model(input vec_t v, output logic [WIDTH-1:0] s, output logic [KW-1:0] c);
    logic [WIDTH:0] t;
    s = '0;
    c = '0;
    for (int i = 0; i < int'(v.n_send); i++) begin
      t = {1'b0, s} + {1'b0, v.ops[i]};
      s = t[WIDTH-1:0];
      if (t[WIDTH] && c != 3'd7) c = c + 3'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [CW-1:0] cnt);
    i_start_valid = 1'b1;
    i_count       = cnt;
    chk("start_ready", o_start_ready, 1);
    @(posedge i_clk); #1;
    i_start_valid = 1'b0;
    i_count       = 4'($urandom_range(0, 15));
  endtask

  task automatic send_op(input logic [WIDTH-1:0] op);
    int waited;
    waited     = 0;
    i_op_valid = 1'b1;
    i_op       = op;
    while (!o_op_ready && waited < 20) begin
      @(posedge i_clk); #1;
      waited++;
    end
    chk("op_ready", o_op_ready, 1);
    @(posedge i_clk); #1;
    i_op_valid = 1'b0;
    i_op       = $urandom;
  endtask

  task automatic get_result(input int hold);
    int waited;
    logic [WIDTH-1:0] es;
    logic [KW-1:0]    ec;
    waited = 0;
    while (!o_res_valid && waited < 30) begin
      @(posedge i_clk); #1;
      waited++;
    end
    chk("res_valid", o_res_valid, 1);
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: got result expected none queued");
    end else begin
      es = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", o_res_valid, 1);
        chk("hold_sum", o_sum, es);
        chk("hold_carry", o_carry_cnt, ec);
        @(posedge i_clk); #1;
      end
      chk("sum", o_sum, es);
      chk("carry_cnt", o_carry_cnt, ec);
      i_res_ready = 1'b1;
      @(posedge i_clk); #1;
      i_res_ready = 1'b0;
      chk("idle_start_ready", o_start_ready, 1);
      chk("idle_busy", o_busy, 0);
      chk("idle_res_valid", o_res_valid, 0);
    end
  endtask

  // Drive one run; the expected result goes into the scoreboard first.
  task automatic drive_vec(input vec_t v);
    logic [WIDTH-1:0] partial;
    exp_q.push_back(v.exp_sum);
    exp_c_q.push_back(v.exp_carry);
    partial = '0;
    do_start(v.count);
    chk("busy_after_start", o_busy, 1);
    if (v.count == 0) begin
      chk("zero_res_valid", o_res_valid, 1);
      chk("zero_op_ready", o_op_ready, 0);
      chk("zero_sum", o_sum, 0);
    end else begin
      for (int i = 0; i < int'(v.n_send); i++) begin
        if (i == int'(v.gap_at)) begin
          for (int g = 0; g < int'(v.gap_len); g++) begin
            @(posedge i_clk); #1;
            chk("gap_hold_sum", o_sum, partial);
            chk("gap_op_ready", o_op_ready, 1);
          end
        end
        send_op(v.ops[i]);
        partial = partial + v.ops[i];
        if (i < int'(v.n_send) - 1) chk("early_res_valid", o_res_valid, 0);
        else                        chk("latency_res_valid", o_res_valid, 1);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    i_rst_n       = 1'b0;
    i_start_valid = 1'b0;
    i_count       = '0;
    i_op_valid    = 1'b0;
    i_op          = '0;
    i_res_ready   = 1'b0;
    #12;
    chk("rst_start_ready", o_start_ready, 1);
    chk("rst_op_ready", o_op_ready, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_carry", o_carry_cnt, 0);
    chk("rst_busy", o_busy, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Table of runs with constant expectations.
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    vecs[0].count = 4; vecs[0].n_send = 4; vecs[0].gap_at = 15;
    vecs[0].ops[0] = 32'hFFFFFFFF; vecs[0].ops[1] = 32'h00000001;
    vecs[0].ops[2] = 32'h00000002; vecs[0].ops[3] = 32'h80000000;
    vecs[0].exp_sum = 32'h80000002; vecs[0].exp_carry = 3'd1;

    vecs[1].count = 0; vecs[1].n_send = 0; vecs[1].gap_at = 15;
    vecs[1].exp_sum = 32'h0; vecs[1].exp_carry = 3'd0;

    vecs[2].count = 8; vecs[2].n_send = 8; vecs[2].gap_at = 3; vecs[2].gap_len = 2;
    for (int k = 0; k < 8; k++) vecs[2].ops[k] = 32'hFFFFFFFF;
    vecs[2].exp_sum = 32'hFFFFFFF8; vecs[2].exp_carry = 3'd7;

    vecs[3].count = 1; vecs[3].n_send = 1; vecs[3].gap_at = 15; vecs[3].hold = 3;
    vecs[3].ops[0] = 32'h12345678;
    vecs[3].exp_sum = 32'h12345678; vecs[3].exp_carry = 3'd0;

    vecs[4].count = 3; vecs[4].n_send = 3; vecs[4].gap_at = 1; vecs[4].gap_len = 1;
    vecs[4].ops[0] = 32'h90000000; vecs[4].ops[1] = 32'h90000000; vecs[4].ops[2] = 32'hA0000000;
    vecs[4].exp_sum = 32'hC0000000; vecs[4].exp_carry = 3'd1;

    vecs[5].count = 2; vecs[5].n_send = 2; vecs[5].gap_at = 15; vecs[5].hold = 1;
    vecs[5].ops[0] = 32'h7FFFFFFF; vecs[5].ops[1] = 32'h80000001;
    vecs[5].exp_sum = 32'h00000000; vecs[5].exp_carry = 3'd1;

    for (int k = 0; k < 6; k++) begin
      drive_vec(vecs[k]);
      get_result(int'(vecs[k].hold));
    end

    // Abort by reset after 2 of 3 operands, then a clean run.
    do_start(4'd3);
    send_op(32'hAAAA0000);
    send_op(32'h5555FFFF);
    i_rst_n = 1'b0;
    #1;
    chk("abort_start_ready", o_start_ready, 1);
    chk("abort_op_ready", o_op_ready, 0);
    chk("abort_res_valid", o_res_valid, 0);
    chk("abort_sum", o_sum, 0);
    chk("abort_carry", o_carry_cnt, 0);
    chk("abort_busy", o_busy, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    v = '0;
    v.count = 2; v.n_send = 2; v.gap_at = 15;
    v.ops[0] = 32'h00000010; v.ops[1] = 32'h00000020;
    v.exp_sum = 32'h00000030; v.exp_carry = 3'd0;
    drive_vec(v);
    get_result(0);

    // Count above MAX_OPS clamps to 8; a 9th beat must not be taken.
    v = '0;
    v.count = 12; v.n_send = 8; v.gap_at = 15;
    for (int k = 0; k < 8; k++) v.ops[k] = 32'(k + 1);
    v.exp_sum = 32'h00000024; v.exp_carry = 3'd0;
    drive_vec(v);
    i_op_valid = 1'b1;
    i_op       = 32'h00000100;
    chk("clamp_op_ready", o_op_ready, 0);
    @(posedge i_clk); #1;
    chk("clamp_op_ready2", o_op_ready, 0);
    chk("clamp_sum_kept", o_sum, 32'h00000024);
    i_op_valid = 1'b0;
    get_result(0);

    // Random runs checked against the reference model.
    for (int r = 0; r < 6; r++) begin
      v = '0;
      v.count  = 4'($urandom_range(1, 8));
      v.n_send = v.count;
      v.gap_at = (r % 2 == 0) ? 4'($urandom_range(0, 7)) : 4'd15;
      v.gap_len = 4'($urandom_range(1, 3));
      v.hold   = 4'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) v.ops[k] = $urandom;
      model(v, v.exp_sum, v.exp_carry);
      drive_vec(v);
      get_result(int'(v.hold));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
